// File: rtl/mdu_if.sv
// Handshake and result bus between the issuing pipeline and the multiply/divide unit.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDop;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDop, start, input busy, done, HI, LO);
  modport slave  (input A, B, MDop, start, output busy, done, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle MIPS-style multiply/divide unit with architectural HI/LO registers.
module mdu (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        sgn_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] mul_res;
  logic [63:0] div_res;
  logic        accept;

  function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [63:0] sp;
    logic        [63:0] up;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    return sgn ? sp : up;
  endfunction

  // Returns {remainder, quotient}; the overflow and zero-divisor cases never reach the divider.
  function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    if (b == 32'd0)
      return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return {32'h0000_0000, 32'h8000_0000};
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  assign mul_res = mul_fn(a_q, b_q, sgn_q);
  assign div_res = div_fn(a_q, b_q, sgn_q);
  assign accept  = (state_q == IDLE) && bus.start &&
                   (bus.MDop >= 4'd1) && (bus.MDop <= 4'd4);

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.A;
      b_q <= bus.B;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            case (bus.MDop)
              4'd1, 4'd2: begin
                state_q <= MUL;
                cnt_q   <= 4'd5;
                busy_q  <= 1'b1;
                sgn_q   <= (bus.MDop == 4'd1);
              end
              4'd3, 4'd4: begin
                state_q <= DIV;
                cnt_q   <= 4'd10;
                busy_q  <= 1'b1;
                sgn_q   <= (bus.MDop == 4'd3);
              end
              4'd5:    hi_q <= bus.A;
              4'd6:    lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (state_q == MUL)
              {hi_q, lo_q} <= mul_res;
            else if (b_q != 32'd0)
              {hi_q, lo_q} <= div_res;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomised scoreboard bench for mdu with directed corner cases.
module tb_mdu;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] hilo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint      sa, sb_, ma, mb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return sa * sb_;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return {hi, lo};
        ma = (sa < 0) ? -sa : sa;
        mb = (sb_ < 0) ? -sb_ : sb_;
        q = ma / mb;
        r = ma % mb;
        if ((sa < 0) != (sb_ < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1, expected 0 (HI=%h LO=%h)", bus.HI, bus.LO);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hilo_result", {bus.HI, bus.LO}, e.hilo);
          chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.A = a;
    bus.B = b;
    bus.MDop = op;
    bus.start = 1'b1;
    if (op >= 4'd1 && op <= 4'd4) begin
      e.hilo = ref_op(op, a, b, model_hi, model_lo);
      e.lat  = (op <= 4'd2) ? 5 : 10;
      sb.push_back(e);
      {model_hi, model_lo} = e.hilo;
    end else if (op == 4'd5) begin
      model_hi = a;
    end else if (op == 4'd6) begin
      model_lo = a;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.MDop = 4'($urandom);
    if (op >= 4'd1 && op <= 4'd4) begin
      chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
    end else begin
      chk("hilo_immediate", {bus.HI, bus.LO}, {model_hi, model_lo});
      chk("no_busy_no_done", {62'd0, bus.busy, bus.done}, 64'd0);
    end
  endtask

  // Waits until busy drops, optionally hammering start with junk meanwhile.
  task automatic wait_idle(input bit junk);
    for (int i = 0; i < 30; i++) begin
      if (!bus.busy) begin
        bus.start = 1'b0;
        return;
      end
      if (junk) begin
        bus.start = 1'b1;
        bus.MDop = 4'($urandom_range(0, 15));
        bus.A = $urandom;
        bus.B = $urandom;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_vec++;
    n_err++;
    $display("FAIL busy_timeout: got busy=1 after 30 cycles, expected 0");
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    bus.MDop = 4'd0;
    bus.start = 1'b0;
    #1;
    chk("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(1'b0);
    chk("mult_neg2x3", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(1'b1);
    chk("multu_max", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(1'b0);
    chk("div_m7_2", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd4, 32'd7, 32'd0);
    wait_idle(1'b0);
    chk("divu_by_zero", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(4'd5, 32'h1234_5678, 32'd0);
    issue(4'd3, 32'd100, 32'hFFFF_FFF9);
    bus.start = 1'b1;
    bus.MDop = 4'd6;
    bus.A = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(1'b0);
    chk("mtlo_ignored_busy", {32'd0, bus.LO}, {32'd0, model_lo});
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(1'b1);
    chk("div_overflow", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);

    issue(4'd1, 32'd1234, 32'd5678);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    #1;
    chk("abort_hilo", {bus.HI, bus.LO}, 64'd0);
    chk("abort_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_busy", {63'd0, bus.busy}, 64'd0);

    issue(4'd1, 32'd7, 32'hFFFF_FFFD);
    wait_idle(1'b0);
    issue(4'd1, 32'h0001_0000, 32'h0001_0000);
    wait_idle(1'b0);
    chk("b2b_second", {bus.HI, bus.LO}, 64'h0000_0001_0000_0000);

    for (int i = 0; i < 10; i++) begin
      op = (i == 0) ? 4'd0 : 4'(6 + i);
      issue(op, $urandom, $urandom);
    end

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 6));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      issue(op, a, b);
      wait_idle(1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("final_hilo", {bus.HI, bus.LO}, {model_hi, model_lo});
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
